memif_line_fetch: RTL and testbench
===================================

Name: memif_line_fetch

Overview:
- Burst-read prefetcher on one downstream port of the PSRAM memory-interface arbiter.
- Given a start address and a word count, it splits the request into bursts of at most BURST_LEN 16-bit words.
- Read data is buffered in an internal FIFO and presented to a valid/ready consumer, e.g. a scanline or pixel feeder in the 1x domain.
- A burst is issued only when the FIFO is guaranteed to have room for every word of that burst.

Parameters:
- BURST_LEN, 64: maximum words per memory burst. Range 1..128.
- FIFO_DEPTH, 256: FIFO depth in 16-bit words. Power of 2, at least BURST_LEN.
- AW, 32: address width.
- CW, 12: width of the word-count input.

Ports:
- clk  in  1  system clock (1x domain).
- rst  in  1  synchronous, active-high reset.
- ctl_addr  in  AW  start word address, sampled on ctl_start.
- ctl_cnt  in  CW  number of words to fetch, sampled on ctl_start. 0 means nothing to fetch.
- ctl_start  in  1  one-cycle start pulse.
- ctl_busy  out  1  high from ctl_start until the last word has been written into the FIFO.
- ctl_done  out  1  one-cycle pulse when the last word of a fetch enters the FIFO.
- mi_addr  out  AW  burst start address.
- mi_len  out  7  burst length minus 1.
- mi_rw  out  1  constant 1 (read).
- mi_valid  out  1  request valid.
- mi_ready  in  1  request accepted.
- mi_wdata  out  16  constant 0.
- mi_wack  in  1  ignored.
- mi_wlast  in  1  ignored.
- mi_rdata  in  16  read data.
- mi_rstb  in  1  read data strobe.
- mi_rlast  in  1  last word of the burst.
- out_data  out  16  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer pop.
- out_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: all outputs 0 except mi_rw=1. FIFO is emptied; state = IDLE.
- State machine:
  - IDLE: waits for a fetch with words remaining.
  - REQ: mi_valid asserted.
  - DATA: waiting for read data.
  - FLUSH: discarding the tail of an aborted burst.
- Remaining counter `rem` (CW bits) and address register `addr` are loaded on ctl_start.
- Space rule: `free = FIFO_DEPTH - out_level - inflight`, where inflight = words requested but not yet received.
  - IDLE -> REQ when rem != 0 and free >= blen, with blen = min(BURST_LEN, rem).
  - Otherwise stay in IDLE.
- REQ:
  - mi_valid=1; mi_addr=addr and mi_len=blen-1 are registered and held stable until mi_ready.
  - On the cycle with mi_valid && mi_ready: addr += blen, rem -= blen, inflight = blen, go to DATA.
- DATA:
  - Each mi_rstb pushes mi_rdata into the FIFO and decrements inflight.
  - On mi_rstb && mi_rlast: go to IDLE.
  - If rem is now 0, pulse ctl_done on that cycle and deassert ctl_busy next cycle.
  - Next burst: one idle cycle minimum before re-entering REQ.
- FIFO:
  - Push and pop in the same cycle leave out_level unchanged.
  - out_data is valid the same cycle out_valid is high (first-word fall-through, registered).
  - Overflow is impossible by the space rule.
  - A pop while empty is ignored.
- ctl_start while busy (restart):
  - FIFO is flushed that cycle; rem and addr are reloaded; ctl_done is not pulsed for the aborted fetch.
  - From REQ not yet accepted: mi_valid drops next cycle and the new fetch starts from IDLE.
  - From REQ with mi_ready in the same cycle as ctl_start: treated as accepted, go to FLUSH.
  - From DATA: go to FLUSH. Remaining strobes of the outstanding burst are discarded; on mi_rlast go to IDLE.
- ctl_cnt=0 on ctl_start: no request is issued; ctl_done pulses one cycle later; ctl_busy stays 0.
- Address arithmetic: modulo 2^AW, wraps silently.

Test Plan:
- Start addr=0x100, cnt=10, out_ready=1, memory returns addr+1 per word -> one request with mi_addr=0x100, mi_len=9; out stream 0x101..0x10A; one ctl_done.
- cnt=150, BURST_LEN=64 -> three requests: (0x0, len 63), (0x40, len 63), (0x80, len 21); 150 words out in order.
- cnt=512, FIFO_DEPTH=256, out_ready=0 -> exactly 4 bursts issued, out_level=256, no fifth request. Raise out_ready -> fetch resumes and completes with 512 words.
- mi_ready held low for 20 cycles -> mi_valid, mi_addr and mi_len stay stable throughout; request accepted on the first mi_ready.
- ctl_start(addr 0x1000, cnt 8) issued mid-DATA of a 64-word burst -> the remaining old words are dropped, FIFO is empty, the next request is at 0x1000 with len 7, and only the new 8 words appear.
- Reset asserted mid-burst -> next cycle: mi_valid=0, out_valid=0, out_level=0, ctl_busy=0.

Source files
------------

// File: rtl/memif_line_fetch_if.sv
// Bus bundle for the line-fetch prefetcher: control port, memory-interface
// request/response port and the FIFO consumer port.
interface memif_line_fetch_if #(
   parameter int AW = 32,
   parameter int CW = 12,
   parameter int LW = 9
);
   logic [AW-1:0] ctl_addr;
   logic [CW-1:0] ctl_cnt;
   logic          ctl_start;
   logic          ctl_busy;
   logic          ctl_done;

   logic [AW-1:0] mi_addr;
   logic [6:0]    mi_len;
   logic          mi_rw;
   logic          mi_valid;
   logic          mi_ready;
   logic [15:0]   mi_wdata;
   logic          mi_wack;
   logic          mi_wlast;
   logic [15:0]   mi_rdata;
   logic          mi_rstb;
   logic          mi_rlast;

   logic [15:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic [LW-1:0] out_level;

   modport master (
      input  ctl_addr, ctl_cnt, ctl_start,
      output ctl_busy, ctl_done,
      output mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
      input  mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast,
      output out_data, out_valid, out_level,
      input  out_ready
   );

   modport slave (
      output ctl_addr, ctl_cnt, ctl_start,
      input  ctl_busy, ctl_done,
      input  mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
      output mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast,
      input  out_data, out_valid, out_level,
      output out_ready
   );
endinterface

// File: rtl/memif_line_fetch.sv
// Burst-read prefetcher: splits a word fetch into bursts of at most BURST_LEN,
// issuing each only when the FIFO is sure to hold all of it.
module memif_line_fetch #(
   parameter int BURST_LEN  = 64,
   parameter int FIFO_DEPTH = 256,
   parameter int AW         = 32,
   parameter int CW         = 12
) (
   input  logic               clk,
   input  logic               rst,
   memif_line_fetch_if.master bus
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DATA, FLUSH} state_t;
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [6:0]    len;
   } burst_req_t;

   state_t        state, state_nx;
   burst_req_t    req_q;
   logic [AW-1:0] addr;
   logic [CW-1:0] rem;
   logic [LW-1:0] inflight, level, free, blen;
   logic          busy_q, zero_done_q;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          restart, flush, accept, rdone, push, pop, go, last_word;
   logic          unused_ok;

   assign unused_ok = &{1'b0, bus.mi_wack, bus.mi_wlast};

   always_comb begin
      blen      = (32'(rem) >= BURST_LEN) ? LW'(BURST_LEN) : LW'(rem);
      free      = LW'(FIFO_DEPTH) - level - inflight;
      restart   = bus.ctl_start;
      flush     = restart && busy_q;
      accept    = (state == REQ) && bus.mi_ready;
      rdone     = bus.mi_rstb && bus.mi_rlast;
      // a restart on the same cycle as a strobe drops that word with the rest
      push      = (state == DATA) && bus.mi_rstb && !restart;
      pop       = bus.out_ready && (level != '0);
      go        = (state == IDLE) && (rem != '0) && (free >= blen) && !restart;
      last_word = push && bus.mi_rlast && (rem == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (go) state_nx = REQ;
         REQ:     if (accept)       state_nx = restart ? FLUSH : DATA;
                  else if (restart) state_nx = IDLE;
         DATA:    if (rdone)        state_nx = IDLE;
                  else if (restart) state_nx = FLUSH;
         FLUSH:   if (rdone)        state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.mi_valid  = (state == REQ);
      bus.mi_addr   = req_q.addr;
      bus.mi_len    = req_q.len;
      bus.mi_rw     = 1'b1;
      bus.mi_wdata  = '0;
      bus.ctl_busy  = busy_q;
      bus.ctl_done  = last_word || zero_done_q;
      bus.out_valid = (level != '0);
      bus.out_level = level;
      bus.out_data  = (level != '0) ? mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr        <= '0;
         rem         <= '0;
         inflight    <= '0;
         req_q       <= '0;
         busy_q      <= 1'b0;
         zero_done_q <= 1'b0;
      end else begin
         zero_done_q <= restart && (bus.ctl_cnt == '0);
         if (restart) begin
            addr   <= bus.ctl_addr;
            rem    <= bus.ctl_cnt;
            busy_q <= (bus.ctl_cnt != '0);
         end else begin
            if (accept) begin
               addr <= addr + AW'(blen);
               rem  <= rem - CW'(blen);
            end
            if (last_word) busy_q <= 1'b0;
         end
         if (go) req_q <= '{addr: addr, len: 7'(blen - LW'(1))};
         // an accepted burst is owed in full even if a restart aborts it
         if (accept)
            inflight <= LW'(req_q.len) + LW'(1);
         else if (((state == DATA) || (state == FLUSH)) && bus.mi_rstb)
            inflight <= rdone ? '0 : inflight - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.mi_rdata;
   end
endmodule

// File: tb/tb_memif_line_fetch.sv
// Bench for memif_line_fetch: responder memory returning addr+1 per word, a
// transaction-level model checked every cycle, plus directed literal checks.
module tb_memif_line_fetch;
   localparam int BL = 64;
   localparam int FD = 256;

   typedef struct {
      logic [31:0] addr;
      logic [6:0]  len;
   } req_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_done  = 0;
   req_t        acc_log[$];
   logic [15:0] pop_log[$];
   req_t        req_q[$];
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   memif_line_fetch_if #(.AW(32), .CW(12), .LW(9)) bus ();
   memif_line_fetch #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .AW(32), .CW(12)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory responder: one idle cycle, then the burst with a gap every 9 words
   initial begin
      logic [31:0] ra;
      int rn;
      bus.mi_rstb = 1'b0; bus.mi_rlast = 1'b0; bus.mi_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.mi_valid && bus.mi_ready && !rst) begin
            ra = bus.mi_addr;
            rn = int'(bus.mi_len) + 1;
            tick();
            for (int i = 0; i < rn; i++) begin
               if (i % 9 == 4) begin
                  bus.mi_rstb = 1'b0; bus.mi_rlast = 1'b0;
                  tick();
               end
               bus.mi_rstb  = 1'b1;
               bus.mi_rdata = 16'(ra + 32'(i) + 32'd1);
               bus.mi_rlast = (i == rn - 1);
               tick();
            end
            bus.mi_rstb = 1'b0; bus.mi_rlast = 1'b0;
         end
      end
   end

   // model: expected words/requests as queues, FIFO occupancy as a count
   initial begin : model
      bit model_on, busy_m, zero_pend, burst_open, burst_stale, prev_hold;
      bit acc, push, pop, done_exp;
      int level_m, push_left, n, b;
      logic [31:0] a, prev_addr;
      logic [6:0]  prev_len;
      logic [15:0] w;
      req_t r;
      model_on = 0; busy_m = 0; zero_pend = 0; burst_open = 0; burst_stale = 0;
      prev_hold = 0; level_m = 0; push_left = 0; prev_addr = '0; prev_len = '0;
      forever begin
         @(negedge clk);
         acc  = bus.mi_valid && bus.mi_ready;
         push = bus.mi_rstb && burst_open && !burst_stale && !bus.ctl_start;
         pop  = bus.out_ready && (level_m != 0);
         done_exp = (push && push_left == 1) || zero_pend;
         if (model_on) begin
            chk("out_level", bus.out_level, level_m);
            chk("out_valid", bus.out_valid, level_m != 0);
            chk("ctl_busy", bus.ctl_busy, busy_m);
            chk("ctl_done", bus.ctl_done, done_exp);
            chk("mi_rw", bus.mi_rw, 1);
            chk("mi_wdata", bus.mi_wdata, 0);
            if (pop) begin
               w = exp_q.pop_front();
               chk("out_data", bus.out_data, w);
               pop_log.push_back(bus.out_data);
            end
            if (prev_hold) begin
               chk("mi_valid_hold", bus.mi_valid, 1);
               chk("mi_addr_hold", bus.mi_addr, prev_addr);
               chk("mi_len_hold", bus.mi_len, prev_len);
            end
            if (acc) begin
               chk("req_pending", req_q.size() != 0, 1);
               if (req_q.size() != 0) begin
                  r = req_q.pop_front();
                  chk("req_addr", bus.mi_addr, r.addr);
                  chk("req_len", bus.mi_len, r.len);
               end
               chk("req_room", level_m + int'(bus.mi_len) + 1 <= FD, 1);
               acc_log.push_back('{bus.mi_addr, bus.mi_len});
            end
            if (bus.ctl_done) n_done++;
         end
         prev_hold = bus.mi_valid && !bus.mi_ready && !bus.ctl_start && !rst;
         prev_addr = bus.mi_addr;
         prev_len  = bus.mi_len;
         if (rst) begin
            model_on = 1; busy_m = 0; zero_pend = 0; burst_open = 0; prev_hold = 0;
            level_m = 0; push_left = 0;
            exp_q.delete(); req_q.delete();
         end else if (model_on) begin
            level_m = level_m + int'(push) - int'(pop);
            if (push) begin
               push_left--;
               if (push_left == 0) busy_m = 0;
            end
            if (bus.mi_rstb && bus.mi_rlast) burst_open = 0;
            if (acc) begin
               burst_open = 1;
               burst_stale = bus.ctl_start;
            end else if (bus.ctl_start) burst_stale = 1;
            zero_pend = 0;
            if (bus.ctl_start) begin
               if (busy_m) begin
                  exp_q.delete();
                  level_m = 0;
               end
               req_q.delete();
               a = bus.ctl_addr;
               n = int'(bus.ctl_cnt);
               for (int i = 0; i < n; i++) exp_q.push_back(16'(a + 32'(i) + 32'd1));
               while (n > 0) begin
                  b = (n > BL) ? BL : n;
                  req_q.push_back('{a, 7'(b - 1)});
                  a = a + 32'(b);
                  n = n - b;
               end
               push_left = int'(bus.ctl_cnt);
               busy_m    = (bus.ctl_cnt != 0);
               zero_pend = (bus.ctl_cnt == 0);
            end
         end
      end
   end

   task automatic start(input logic [31:0] a, input logic [11:0] c);
      bus.ctl_addr = a; bus.ctl_cnt = c; bus.ctl_start = 1'b1;
      tick();
      bus.ctl_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!bus.ctl_busy && bus.out_level == 0) begin
            ok = 1;
            break;
         end
      end
      chk("wait_idle_timeout", ok, 1);
      repeat (3) tick();
   endtask

   initial begin
      int a0, p0, d0, a1, p1;
      bit ok;
      bus.ctl_addr = '0; bus.ctl_cnt = '0; bus.ctl_start = 1'b0;
      bus.mi_ready = 1'b1; bus.mi_wack = 1'b0; bus.mi_wlast = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_mi_valid", bus.mi_valid, 0);
      chk("rst_mi_rw", bus.mi_rw, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_level", bus.out_level, 0);
      chk("rst_busy", bus.ctl_busy, 0);
      rst = 1'b0;
      tick();

      // single short fetch
      a0 = acc_log.size(); p0 = pop_log.size(); d0 = n_done;
      start(32'h100, 12'd10);
      wait_idle(500);
      chk("t1_nreq", acc_log.size() - a0, 1);
      chk("t1_addr", acc_log[a0].addr, 32'h100);
      chk("t1_len", acc_log[a0].len, 9);
      chk("t1_nwords", pop_log.size() - p0, 10);
      chk("t1_first", pop_log[p0], 16'h101);
      chk("t1_last", pop_log[p0+9], 16'h10A);
      chk("t1_done", n_done - d0, 1);

      // three bursts
      a0 = acc_log.size(); p0 = pop_log.size();
      start(32'h0, 12'd150);
      wait_idle(1000);
      chk("t2_nreq", acc_log.size() - a0, 3);
      chk("t2_r1", {acc_log[a0+1].addr, 1'b0, acc_log[a0+1].len}, {32'h40, 8'd63});
      chk("t2_r2", {acc_log[a0+2].addr, 1'b0, acc_log[a0+2].len}, {32'h80, 8'd21});
      chk("t2_nwords", pop_log.size() - p0, 150);
      chk("t2_last", pop_log[p0+149], 16'h96);

      // backpressure: FIFO fills after four bursts
      bus.out_ready = 1'b0;
      a0 = acc_log.size(); p0 = pop_log.size();
      start(32'h2000, 12'd512);
      repeat (450) tick();
      chk("t3_nreq_full", acc_log.size() - a0, 4);
      chk("t3_level_full", bus.out_level, 256);
      chk("t3_busy", bus.ctl_busy, 1);
      bus.out_ready = 1'b1;
      wait_idle(3000);
      chk("t3_nreq", acc_log.size() - a0, 8);
      chk("t3_nwords", pop_log.size() - p0, 512);
      chk("t3_last", pop_log[p0+511], 16'h2200);

      // request held while mi_ready is low
      bus.mi_ready = 1'b0;
      a0 = acc_log.size();
      start(32'h3000, 12'd5);
      repeat (20) tick();
      chk("t4_valid", bus.mi_valid, 1);
      chk("t4_addr", bus.mi_addr, 32'h3000);
      chk("t4_len", bus.mi_len, 4);
      chk("t4_noacc", acc_log.size() - a0, 0);
      bus.mi_ready = 1'b1;
      wait_idle(300);
      chk("t4_nreq", acc_log.size() - a0, 1);

      // restart in the middle of a 64-word burst
      d0 = n_done;
      start(32'h4000, 12'd64);
      p0 = pop_log.size();
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (pop_log.size() >= p0 + 10) begin ok = 1; break; end
      end
      chk("t5_reach_mid", ok, 1);
      start(32'h1000, 12'd8);
      chk("t5_flushed", bus.out_level, 0);
      chk("t5_flushed_valid", bus.out_valid, 0);
      a1 = acc_log.size(); p1 = pop_log.size();
      wait_idle(500);
      chk("t5_nreq", acc_log.size() - a1, 1);
      chk("t5_addr", acc_log[a1].addr, 32'h1000);
      chk("t5_len", acc_log[a1].len, 7);
      chk("t5_nwords", pop_log.size() - p1, 8);
      chk("t5_first", pop_log[p1], 16'h1001);
      chk("t5_last", pop_log[p1+7], 16'h1008);
      chk("t5_done", n_done - d0, 1);

      // zero-length fetch
      a0 = acc_log.size(); d0 = n_done;
      start(32'h500, 12'd0);
      chk("t6_busy", bus.ctl_busy, 0);
      tick();
      chk("t6_done", n_done - d0, 1);
      repeat (5) tick();
      chk("t6_noreq", acc_log.size() - a0, 0);

      // address wrap across 2^32
      a0 = acc_log.size(); p0 = pop_log.size();
      start(32'hFFFF_FFE0, 12'd70);
      wait_idle(600);
      chk("t7_nreq", acc_log.size() - a0, 2);
      chk("t7_r0", {acc_log[a0].addr, 1'b0, acc_log[a0].len}, {32'hFFFF_FFE0, 8'd63});
      chk("t7_r1", {acc_log[a0+1].addr, 1'b0, acc_log[a0+1].len}, {32'h20, 8'd5});
      chk("t7_wrap_word", pop_log[p0+31], 16'h0000);
      chk("t7_last", pop_log[p0+69], 16'h0026);

      // reset in the middle of a burst
      bus.out_ready = 1'b0;
      start(32'h6000, 12'd40);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.out_level >= 5) begin ok = 1; break; end
      end
      chk("t8_reach_mid", ok, 1);
      rst = 1'b1;
      tick();
      chk("t8_mi_valid", bus.mi_valid, 0);
      chk("t8_out_valid", bus.out_valid, 0);
      chk("t8_out_level", bus.out_level, 0);
      chk("t8_busy", bus.ctl_busy, 0);
      rst = 1'b0;
      repeat (80) tick();
      bus.out_ready = 1'b1;
      p0 = pop_log.size();
      start(32'h7000, 12'd3);
      wait_idle(300);
      chk("t8_nwords", pop_log.size() - p0, 3);
      chk("t8_first", pop_log[p0], 16'h7001);

      chk("end_words_left", exp_q.size(), 0);
      chk("end_reqs_left", req_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end
endmodule
